// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: computes A - B one bit per clock through a single
// full-subtractor cell, with the borrow held in a flip-flop between bits.
module serial_sub_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  generate
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("serial_sub_ctrl: WIDTH must be in 2..32");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] rr;
  logic             br;
  logic [CW-1:0]    cnt;

  logic a0, b0, h, g, d, p, br_next;
  logic [WIDTH-1:0] rr_next;

  // Full-subtractor cell built from two half-subtractor stages.
  always_comb begin
    a0      = ra[0];
    b0      = rb[0];
    h       = a0 ^ b0;
    g       = ~a0 & b0;
    d       = h ^ br;
    p       = ~h & br;
    br_next = g | p;
    rr_next = {d, rr[WIDTH-1:1]};
  end

  // Sequencer: result and borrow become visible only on SHIFT -> DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      rr    <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
      Diff  <= '0;
      Bout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            ra    <= A;
            rb    <= B;
            rr    <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            Busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          ra  <= ra >> 1;
          rb  <= rb >> 1;
          rr  <= rr_next;
          br  <= br_next;
          if (cnt == LAST) begin
            cnt   <= '0;
            Diff  <= rr_next;
            Bout  <= br_next;
            Done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          Done  <= 1'b0;
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          Done  <= 1'b0;
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl: directed vectors, corner sequences
// and randomized regression at WIDTH=8 and WIDTH=16 against an arithmetic model.
module tb_serial_sub_ctrl;

  localparam int unsigned W8  = 8;
  localparam int unsigned W16 = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        s8, s16;
  logic [7:0]  a8, b8, diff8;
  logic [15:0] a16, b16, diff16;
  logic        busy8, done8, bout8;
  logic        busy16, done16, bout16;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_sub_ctrl #(.WIDTH(W8)) u8 (
    .clk(clk), .rst(rst), .Start(s8), .A(a8), .B(b8),
    .Busy(busy8), .Done(done8), .Diff(diff8), .Bout(bout8)
  );

  serial_sub_ctrl #(.WIDTH(W16)) u16 (
    .clk(clk), .rst(rst), .Start(s16), .A(a16), .B(b16),
    .Busy(busy16), .Done(done16), .Diff(diff16), .Bout(bout16)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       bout;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: {borrow, diff} is the (WIDTH+1)-bit difference of zero-extended operands.
  function automatic logic [8:0] ref8(input logic [7:0] a, input logic [7:0] b);
    return {1'b0, a} - {1'b0, b};
  endfunction

  function automatic logic [16:0] ref16(input logic [15:0] a, input logic [15:0] b);
    return {1'b0, a} - {1'b0, b};
  endfunction

  // One full operation on the 8-bit instance with latency/busy/result checks.
  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] ed, input logic eb, input string tag);
    int lat = 0;
    int busy_n = 0;
    logic [7:0] d = 8'h00;
    logic bo = 1'b0;
    @(posedge clk) #1;
    s8 = 1'b1; a8 = a; b8 = b;
    @(posedge clk) #1;
    s8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    for (int i = 0; i < 40 && lat == 0; i++) begin
      @(negedge clk);
      if (busy8) busy_n++;
      if (done8) begin
        lat = i + 1;
        d   = diff8;
        bo  = bout8;
      end
    end
    chk({tag, " latency"}, 32'(lat), 32'(W8 + 1));
    chk({tag, " busy cycles"}, 32'(busy_n), 32'(W8 + 1));
    chk({tag, " diff"}, 32'(d), 32'(ed));
    chk({tag, " bout"}, 32'(bo), 32'(eb));
    @(negedge clk);
    chk({tag, " idle busy/done"}, {30'd0, busy8, done8}, 32'd0);
    chk({tag, " diff held"}, 32'(diff8), 32'(ed));
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input string tag);
    logic [16:0] e = ref16(a, b);
    int lat = 0;
    logic [15:0] d = 16'h0;
    logic bo = 1'b0;
    @(posedge clk) #1;
    s16 = 1'b1; a16 = a; b16 = b;
    @(posedge clk) #1;
    s16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
    for (int i = 0; i < 60 && lat == 0; i++) begin
      @(negedge clk);
      if (done16) begin
        lat = i + 1;
        d   = diff16;
        bo  = bout16;
      end
    end
    chk({tag, " latency"}, 32'(lat), 32'(W16 + 1));
    chk({tag, " diff"}, 32'(d), 32'(e[15:0]));
    chk({tag, " bout"}, 32'(bo), 32'(e[16]));
  endtask

  vec_t vecs[4];

  initial begin
    int ndone;
    int first, second, stable_bad;
    logic [7:0] d1, d2, d;
    logic bo1, bo2, bo;
    logic [7:0] ra, rb;
    logic [8:0] e8;

    vecs[0] = '{a: 8'h5A, b: 8'h23, diff: 8'h37, bout: 1'b0};
    vecs[1] = '{a: 8'h00, b: 8'h01, diff: 8'hFF, bout: 1'b1};
    vecs[2] = '{a: 8'hFF, b: 8'h00, diff: 8'hFF, bout: 1'b0};
    vecs[3] = '{a: 8'hAA, b: 8'hAA, diff: 8'h00, bout: 1'b0};

    rst = 1'b1;
    s8 = 1'b0; a8 = 8'h0; b8 = 8'h0;
    s16 = 1'b0; a16 = 16'h0; b16 = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset u8 outputs", {22'd0, busy8, done8, diff8}, 32'd0);
    chk("reset u8 bout", 32'(bout8), 32'd0);
    chk("reset u16 outputs", {14'd0, busy16, done16, diff16}, 32'd0);
    chk("reset u16 bout", 32'(bout16), 32'd0);
    @(posedge clk) #1;
    rst = 1'b0;

    for (int i = 0; i < 4; i++)
      op8(vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].bout, $sformatf("vec%0d", i));

    // Start pulsed during SHIFT must be ignored and not queued.
    @(posedge clk) #1;
    s8 = 1'b1; a8 = 8'h10; b8 = 8'h01;
    @(posedge clk) #1;
    s8 = 1'b0;
    @(posedge clk) #1;
    @(posedge clk) #1;
    s8 = 1'b1; a8 = 8'h80; b8 = 8'h7F;
    @(posedge clk) #1;
    s8 = 1'b0;
    ndone = 0; d = 8'h0; bo = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done8) begin
        ndone++;
        d  = diff8;
        bo = bout8;
      end
    end
    chk("ignore done count", 32'(ndone), 32'd1);
    chk("ignore diff", 32'(d), 32'h0F);
    chk("ignore bout", 32'(bo), 32'd0);

    op8(8'h00, 8'h01, 8'hFF, 1'b1, "pre-reset");

    // Asynchronous reset mid-operation aborts and clears outputs.
    @(posedge clk) #1;
    s8 = 1'b1; a8 = 8'h40; b8 = 8'h05;
    @(posedge clk) #1;
    s8 = 1'b0;
    repeat (3) @(posedge clk) #1;
    #2 rst = 1'b1;
    #1;
    chk("async rst busy/done", {30'd0, busy8, done8}, 32'd0);
    chk("async rst diff", 32'(diff8), 32'd0);
    chk("async rst bout", 32'(bout8), 32'd0);
    @(posedge clk) #1;
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done8 || busy8) ndone++;
    end
    chk("no activity after abort", 32'(ndone), 32'd0);
    op8(8'h09, 8'h03, 8'h06, 1'b0, "post-reset");

    // Start held high: back-to-back operations, one every WIDTH+2 cycles.
    @(posedge clk) #1;
    s8 = 1'b1; a8 = 8'h33; b8 = 8'h11;
    first = -1; second = -1; stable_bad = 0;
    d1 = 8'h0; d2 = 8'h0; bo1 = 1'b1; bo2 = 1'b0;
    for (int i = 0; i < 40 && second < 0; i++) begin
      @(negedge clk);
      if (done8) begin
        if (first < 0) begin
          first = i; d1 = diff8; bo1 = bout8;
          a8 = 8'h01; b8 = 8'h02;
        end else begin
          second = i; d2 = diff8; bo2 = bout8;
          s8 = 1'b0;
        end
      end else if (first >= 0 && diff8 !== 8'h22) begin
        stable_bad++;
      end
    end
    chk("b2b done spacing", 32'(second - first), 32'd10);
    chk("b2b first diff", 32'(d1), 32'h22);
    chk("b2b first bout", 32'(bo1), 32'd0);
    chk("b2b second diff", 32'(d2), 32'hFF);
    chk("b2b second bout", 32'(bo2), 32'd1);
    chk("b2b diff stable", 32'(stable_bad), 32'd0);
    repeat (3) @(negedge clk);

    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      e8 = ref8(ra, rb);
      op8(ra, rb, e8[7:0], e8[8], $sformatf("rand8 %0d a=%0h b=%0h", n, ra, rb));
    end

    op16(16'h0000, 16'h0001, "w16 underflow");
    op16(16'hFFFF, 16'hFFFF, "w16 equal");
    for (int n = 0; n < 1000; n++)
      op16(16'($urandom), 16'($urandom), $sformatf("rand16 %0d", n));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
